// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the MEM stage and the data memory port.
// Stores queue in FIFO order and drain whenever no load claims the port.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_l_or_s,
  input  logic [1:0]       req_sel,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wd,
  input  logic [31:0]      req_pc,
  output logic             stall,
  output logic [1:0]       dm_l_or_s,
  output logic [1:0]       dm_sel,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wd,
  output logic [31:0]      dm_pc,
  output logic             sb_empty,
  output logic [PTR_W:0]   sb_count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);

  logic [1:0]       e_sel  [DEPTH];
  logic [31:0]      e_addr [DEPTH];
  logic [31:0]      e_wd   [DEPTH];
  logic [31:0]      e_pc   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic             is_ld;
  logic             is_st;
  logic             hazard;
  logic             full;
  logic             ld_go;
  logic             dr_go;
  logic             enq;
  logic [DEPTH-1:0] hit;
  logic [PTR_W-1:0] off;

  assign is_ld = (req_l_or_s == 2'b01);
  assign is_st = (req_l_or_s == 2'b10);

  // An entry is live when its distance from head is below count.
  always_comb begin
    hit = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PTR_W'(i) - head;
      hit[i] = ({1'b0, off} < count) &&
               (e_addr[i][31:2] == req_addr[31:2]);
    end
  end

  assign hazard = is_ld && (|hit);
  assign full   = is_st && (count == FULL);
  assign stall  = !reset && (hazard || full);

  assign ld_go  = !reset && is_ld && !hazard;
  assign dr_go  = !reset && !ld_go && (count != '0);
  assign enq    = !reset && is_st && !full;

  always_comb begin
    dm_l_or_s = 2'b00;
    dm_sel    = 2'b00;
    dm_addr   = '0;
    dm_wd     = '0;
    dm_pc     = '0;
    unique case (1'b1)
      ld_go: begin
        dm_l_or_s = 2'b01;
        dm_sel    = req_sel;
        dm_addr   = req_addr;
        dm_wd     = req_wd;
        dm_pc     = req_pc;
      end
      dr_go: begin
        dm_l_or_s = 2'b10;
        dm_sel    = e_sel[head];
        dm_addr   = e_addr[head];
        dm_wd     = e_wd[head];
        dm_pc     = e_pc[head];
      end
      default: ;
    endcase
  end

  assign sb_empty = reset || (count == '0);
  assign sb_count = reset ? '0 : count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)
        tail <= tail + PTR_W'(1);
      if (dr_go)
        head <= head + PTR_W'(1);
      unique case ({enq, dr_go})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end

  // Payload needs no reset; validity lives in head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      e_sel[tail]  <= req_sel;
      e_addr[tail] <= req_addr;
      e_wd[tail]   <= req_wd;
      e_pc[tail]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Randomized bench for mem_store_buffer against a queue-based model
// with a byte-addressed data memory on the DM side.
module tb_mem_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_l_or_s;
  logic [1:0]       req_sel;
  logic [31:0]      req_addr;
  logic [31:0]      req_wd;
  logic [31:0]      req_pc;
  logic             stall;
  logic [1:0]       dm_l_or_s;
  logic [1:0]       dm_sel;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wd;
  logic [31:0]      dm_pc;
  logic             sb_empty;
  logic [PTR_W:0]   sb_count;

  mem_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .req_l_or_s(req_l_or_s), .req_sel(req_sel),
    .req_addr(req_addr), .req_wd(req_wd), .req_pc(req_pc),
    .stall(stall), .dm_l_or_s(dm_l_or_s), .dm_sel(dm_sel),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pc;
  } st_t;

  st_t         q[$];
  logic [63:0] exp_log[$];
  logic [63:0] act_log[$];
  logic [7:0]  ref_m[int unsigned];
  logic [7:0]  dm_m[int unsigned];

  int n_chk  = 0;
  int n_fail = 0;
  int pc_ctr = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mem_wr(input bit r, input logic [1:0] sel,
                        input logic [31:0] a, input logic [31:0] wd);
    int unsigned base;
    int n;
    n    = (sel == 2'b00) ? 4 : (sel == 2'b01) ? 2 : 1;
    base = (sel == 2'b00) ? {a[31:2], 2'b00} :
           (sel == 2'b01) ? {a[31:1], 1'b0} : a;
    for (int k = 0; k < n; k++) begin
      if (r) ref_m[base + k] = wd[8*k +: 8];
      else   dm_m[base + k]  = wd[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] mem_rd(input bit r, input logic [31:0] a);
    logic [31:0] w;
    int unsigned b;
    w = '0;
    b = {a[31:2], 2'b00};
    for (int k = 0; k < 4; k++) begin
      if (r && ref_m.exists(b + k))
        w[8*k +: 8] = ref_m[b + k];
      else if (!r && dm_m.exists(b + k))
        w[8*k +: 8] = dm_m[b + k];
    end
    return w;
  endfunction

  // One clock cycle with a request held; called just after a negedge.
  task automatic cyc(input logic [1:0] op, input logic [1:0] sel,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] pc, output bit stl);
    bit          hz;
    bit          e_stall;
    logic [1:0]  e_op;
    st_t         e;
    logic [1:0]  a_op;
    logic [1:0]  a_sel;
    logic [31:0] a_addr;
    logic [31:0] a_wd;
    req_l_or_s = op;
    req_sel    = sel;
    req_addr   = addr;
    req_wd     = wd;
    req_pc     = pc;
    #2;
    hz = 1'b0;
    if (op == 2'b01)
      foreach (q[i])
        if (q[i].addr[31:2] == addr[31:2]) hz = 1'b1;
    e_stall = hz || (op == 2'b10 && q.size() == DEPTH);
    e = '{2'b00, 32'h0, 32'h0, 32'h0};
    e_op = 2'b00;
    if (op == 2'b01 && !hz) begin
      e_op = 2'b01;
      e = '{sel, addr, wd, pc};
    end else if (q.size() > 0) begin
      e_op = 2'b10;
      e = q[0];
    end
    check("stall", {31'b0, stall}, {31'b0, e_stall});
    check("dm_l_or_s", {30'b0, dm_l_or_s}, {30'b0, e_op});
    check("dm_sel", {30'b0, dm_sel}, {30'b0, e.sel});
    check("dm_addr", dm_addr, e.addr);
    check("dm_wd", dm_wd, e.wd);
    check("dm_pc", dm_pc, e.pc);
    check("sb_count", {29'b0, sb_count}, q.size());
    check("sb_empty", {31'b0, sb_empty}, {31'b0, q.size() == 0});
    if (e_op == 2'b01)
      check("ld_data", mem_rd(1'b0, dm_addr), mem_rd(1'b1, addr));
    a_op   = dm_l_or_s;
    a_sel  = dm_sel;
    a_addr = dm_addr;
    a_wd   = dm_wd;
    @(posedge clk);
    if (a_op == 2'b10) begin
      mem_wr(1'b0, a_sel, a_addr, a_wd);
      act_log.push_back({a_addr, a_wd});
    end
    if (e_op == 2'b10) begin
      mem_wr(1'b1, e.sel, e.addr, e.wd);
      exp_log.push_back({e.addr, e.wd});
      void'(q.pop_front());
    end
    if (op == 2'b10 && !e_stall)
      q.push_back('{sel, addr, wd, pc});
    @(negedge clk);
    stl = e_stall;
  endtask

  // Holds a request until accepted; returns cycles spent stalled.
  task automatic issue(input logic [1:0] op, input logic [1:0] sel,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int waits);
    bit stl;
    waits = 0;
    pc_ctr += 4;
    do begin
      cyc(op, sel, addr, wd, pc_ctr, stl);
      if (stl) waits++;
    end while (stl && waits < 20);
    if (stl) check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    int w;
    for (int i = 0; i < n; i++) issue(2'b00, 2'b00, 32'h0, 32'h0, w);
  endtask

  initial begin
    int w;
    logic [1:0]  op;
    logic [1:0]  sel;
    logic [31:0] a;
    reset      = 1'b1;
    req_l_or_s = 2'b10;
    req_sel    = 2'b00;
    req_addr   = 32'h40;
    req_wd     = 32'h1234;
    req_pc     = 32'h4;
    #2;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_dm_op", {30'b0, dm_l_or_s}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_empty", {31'b0, sb_empty}, 32'd1);
    check("rst_count", {29'b0, sb_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(2'b10, 2'b00, 32'h10, 32'hDEADBEEF, w);
    idle(2);

    issue(2'b10, 2'b10, 32'h23, 32'h000000AB, w);
    issue(2'b01, 2'b00, 32'h20, 32'h0, w);
    check("byte_hazard_waits", w, 32'd1);
    check("byte_ld_word", mem_rd(1'b0, 32'h20), 32'hAB000000);

    issue(2'b10, 2'b00, 32'h20, 32'h55667788, w);
    issue(2'b01, 2'b00, 32'h24, 32'h0, w);
    check("other_word_waits", w, 32'd0);

    for (int i = 0; i < 10; i++) begin
      issue(2'b10, 2'b00, 32'h300 + 32'(i * 4), 32'hA000 + 32'(i), w);
      idle(1 + (i % 2));
    end

    issue(2'b10, 2'b00, 32'h400, 32'hCAFE0001, w);
    req_l_or_s = 2'b01;
    req_addr   = 32'h400;
    #2;
    reset = 1'b1;
    #1;
    check("async_dm_op", {30'b0, dm_l_or_s}, 32'd0);
    check("async_dm_wd", dm_wd, 32'd0);
    check("async_stall", {31'b0, stall}, 32'd0);
    check("async_empty", {31'b0, sb_empty}, 32'd1);
    @(posedge clk);
    #1;
    check("rst_hold_dm_op", {30'b0, dm_l_or_s}, 32'd0);
    @(negedge clk);
    req_l_or_s = 2'b00;
    reset = 1'b0;
    q.delete();
    idle(2);

    for (int i = 0; i < 300; i++) begin
      int r;
      r   = $urandom_range(0, 9);
      op  = (r < 4) ? 2'b10 : (r < 7) ? 2'b01 : ((r == 8) ? 2'b11 : 2'b00);
      sel = 2'($urandom_range(0, 2));
      a   = 32'h200 + 32'($urandom_range(0, 31));
      if (sel == 2'b00) a[1:0] = 2'b00;
      if (sel == 2'b01) a[0] = 1'b0;
      issue(op, sel, a, $urandom, w);
    end
    idle(DEPTH + 1);

    check("log_len", act_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < act_log.size(); i++)
      if (act_log[i] !== exp_log[i])
        check("log_entry", act_log[i][31:0] ^ act_log[i][63:32],
              exp_log[i][31:0] ^ exp_log[i][63:32]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
